avg_frame_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one frame-averaging datapath between NUM_SRC sample sources.
- Grants one source per frame, clears the averager, streams FRAME_LEN samples into it and waits for its result.
- Returns the result tagged with the source index.
- Sits between the upstream sample producers and the averaging unit.

---
 rtl/avg_frame_arbiter_if.sv | 49 ++++
 rtl/avg_frame_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_avg_frame_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avg_frame_arbiter_if.sv
// Source, averager and result signals shared by avg_frame_arbiter.
// timeout_err exists only when AVG_TIMEOUT_EN is defined.
interface avg_frame_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 4,
  parameter int IDW     = 2
);
  logic [NUM_SRC-1:0]    src_req;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC*DW-1:0] src_data;
  logic [NUM_SRC-1:0]    src_gnt;
  logic [NUM_SRC-1:0]    src_ack;
  logic                  avg_start;
  logic                  avg_req;
  logic [DW-1:0]         avg_data;
  logic                  avg_done;
  logic [DW-1:0]         avg_result;
  logic                  res_valid;
  logic [DW-1:0]         res_data;
  logic [IDW-1:0]        res_id;
  logic                  busy;
`ifdef AVG_TIMEOUT_EN
  logic                  timeout_err;
`endif

  modport master (
    input  src_req, src_valid, src_data,
    input  avg_done, avg_result,
`ifdef AVG_TIMEOUT_EN
    output timeout_err,
`endif
    output src_gnt, src_ack,
    output avg_start, avg_req, avg_data,
    output res_valid, res_data, res_id,
    output busy
  );

  modport slave (
    output src_req, src_valid, src_data,
    output avg_done, avg_result,
`ifdef AVG_TIMEOUT_EN
    input  timeout_err,
`endif
    input  src_gnt, src_ack,
    input  avg_start, avg_req, avg_data,
    input  res_valid, res_data, res_id,
    input  busy
  );
endinterface

// File: rtl/avg_frame_arbiter.sv
// Round-robin frame sequencer sharing one averager among NUM_SRC sources.
// Define AVG_TIMEOUT_EN to bound WAIT by TIMEOUT cycles (adds timeout_err).
module avg_frame_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DW        = 4,
  parameter int FRAME_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input logic clk_2,
  input logic rst,
  avg_frame_arbiter_if.master bus
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW  = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE, START, LOAD, WAIT
  } state_t;

  state_t state, state_nx;

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     sel_id;
  logic [IDW-1:0]     nxt_ptr;
  logic               sel_vld;
  logic [CW-1:0]      cnt;
  logic [NUM_SRC-1:0] gnt_q;
  logic [NUM_SRC-1:0] one;
  logic               res_valid_q;
  logic [DW-1:0]      res_data_q;
  logic [IDW-1:0]     res_id_q;

  logic grant, release_f, capture;
  logic clr_cnt, inc_cnt;
  logic req_g, vld_g;
  logic [DW-1:0] data_g;

`ifdef AVG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          tmo;
  logic          tmo_q;
`endif

  assign one    = {{(NUM_SRC-1){1'b0}}, 1'b1};
  assign req_g  = bus.src_req[gnt_id];
  assign vld_g  = bus.src_valid[gnt_id];
  assign data_g = bus.src_data[int'(gnt_id)*DW +: DW];

  assign nxt_ptr = (gnt_id == IDW'(NUM_SRC-1))
                 ? '0 : gnt_id + 1'b1;

  // first requester at or above ptr, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!sel_vld && bus.src_req[idx]) begin
        sel_vld = 1'b1;
        sel_id  = IDW'(idx);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.avg_start = (state == START);
  assign bus.avg_req   = (state == LOAD) & vld_g;
  assign bus.avg_data  = (state == LOAD) ? data_g : '0;
  assign bus.src_ack   = bus.avg_req ? (one << gnt_id) : '0;
  assign bus.src_gnt   = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
`ifdef AVG_TIMEOUT_EN
  assign bus.timeout_err = tmo_q;
`endif

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    release_f = 1'b0;
    capture   = 1'b0;
    clr_cnt   = 1'b0;
    inc_cnt   = 1'b0;
`ifdef AVG_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (sel_vld) begin
          grant    = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        clr_cnt = 1'b1;
        if (!req_g) begin
          release_f = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        if (!req_g) begin
          release_f = 1'b1;
          state_nx  = IDLE;
        end else if (vld_g) begin
          inc_cnt = 1'b1;
          if (cnt == CW'(FRAME_LEN-1))
            state_nx = WAIT;
        end
      end
      WAIT: begin
        if (bus.avg_done) begin
          capture   = 1'b1;
          release_f = 1'b1;
          state_nx  = IDLE;
        end
`ifdef AVG_TIMEOUT_EN
        else if (wcnt == TW'(TIMEOUT-1)) begin
          tmo       = 1'b1;
          release_f = 1'b1;
          state_nx  = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      gnt_id      <= '0;
      gnt_q       <= '0;
      cnt         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      if (grant) begin
        gnt_id <= sel_id;
        gnt_q  <= one << sel_id;
      end
      if (release_f) begin
        gnt_q <= '0;
        ptr   <= nxt_ptr;
      end
      if (clr_cnt)      cnt <= '0;
      else if (inc_cnt) cnt <= cnt + 1'b1;
      res_valid_q <= capture;
      if (capture) begin
        res_data_q <= bus.avg_result;
        res_id_q   <= gnt_id;
      end
    end
  end

`ifdef AVG_TIMEOUT_EN
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo;
      if (state_nx == WAIT && state != WAIT)
        wcnt <= '0;
      else if (state == WAIT)
        wcnt <= wcnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_avg_frame_arbiter.sv
// Scoreboard bench for avg_frame_arbiter with a two-cycle averager model.
// Timeout scenario compiled only when AVG_TIMEOUT_EN is defined.
module tb_avg_frame_arbiter;
  localparam int NS  = 4;
  localparam int DW  = 4;
  localparam int FL  = 4;
  localparam int IDW = 2;

  logic clk_2 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_2 = ~clk_2;

  avg_frame_arbiter_if #(
    .NUM_SRC(NS), .DW(DW), .IDW(IDW)
  ) bus ();

  avg_frame_arbiter #(
    .NUM_SRC(NS), .DW(DW),
    .FRAME_LEN(FL), .TIMEOUT(15)
  ) dut (
    .clk_2(clk_2),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct { int id; int d; } exp_t;

  int n_pass = 0;
  int n_tot  = 0;
  exp_t exp_q[$];
  logic [DW-1:0] smp [NS][16];
  logic [31:0] vpat [NS];
  int frames_left [NS];
  int abort_after [NS];
  int pos [NS];
  int kcnt [NS];
  logic [NS-1:0] dprev, prev_gnt;
  int n_start, n_req, n_to, bad_gnt, bad_ack;
  int cyc, c_req4, t_cyc, dly, acc, nacc;
  bit mute;
  int gnt_log[$];
  int ack_pos[$];
  logic [DW-1:0] seen_q[$];

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      int cur;
      logic r, vb;
      if (!rst) begin
        pos[i] = 0;
        dprev[i] = 1'b0;
      end
      if (dprev[i] && !bus.src_gnt[i] && frames_left[i] > 0)
        frames_left[i]--;
      dprev[i] = bus.src_gnt[i];
      cur = pos[i];
      if (bus.src_gnt[i]) pos[i]++;
      else pos[i] = 0;
      r = (frames_left[i] > 0) &&
          !(bus.src_gnt[i] && abort_after[i] >= 0 &&
            kcnt[i] >= abort_after[i]);
      vb = (cur < 32) ? vpat[i][cur] : 1'b1;
      bus.src_req[i]   = r;
      bus.src_valid[i] = r && (bus.src_gnt[i] ? vb : 1'b1);
      bus.src_data[i*DW +: DW] = smp[i][kcnt[i] % 16];
    end
  endtask

  task automatic sample();
    exp_t e;
    cyc++;
    bus.avg_done = 1'b0;
    if (!rst) begin
      dly = 0; nacc = 0; acc = 0;
      prev_gnt = '0;
      for (int i = 0; i < NS; i++) kcnt[i] = 0;
      return;
    end
    if (dly > 0) begin
      dly--;
      if (dly == 0 && !mute) begin
        bus.avg_done   = 1'b1;
        bus.avg_result = DW'(acc / FL);
      end
    end
    if (bus.avg_start) begin
      acc = 0; nacc = 0; n_start++;
    end
    if (bus.avg_req) begin
      acc += int'(bus.avg_data);
      nacc++; n_req++;
      seen_q.push_back(bus.avg_data);
      if (nacc == FL) begin
        dly = 2; c_req4 = cyc;
      end
    end
    if ($countones(bus.src_gnt) > 1) bad_gnt++;
    if ((bus.src_ack & ~(bus.src_valid & bus.src_gnt)) != '0 ||
        $countones(bus.src_ack) > 1) bad_ack++;
    for (int i = 0; i < NS; i++) begin
      if (bus.src_ack[i]) begin
        kcnt[i]++;
        ack_pos.push_back(pos[i] - 1);
      end else if (!bus.src_gnt[i]) begin
        kcnt[i] = 0;
      end
      if (bus.src_gnt[i] && prev_gnt == '0)
        gnt_log.push_back(i);
    end
    prev_gnt = bus.src_gnt;
    if (bus.res_valid) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL res_unexpected: got id=%0d data=%0d, required none",
                 bus.res_id, bus.res_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.res_id === IDW'(e.id) && bus.res_data === DW'(e.d))
          n_pass++;
        else
          $display("FAIL res_sb: got id=%0d data=%0d, required id=%0d data=%0d",
                   bus.res_id, bus.res_data, e.id, e.d);
      end
    end
`ifdef AVG_TIMEOUT_EN
    if (bus.timeout_err) begin
      n_to++; t_cyc = cyc;
    end
`endif
  endtask

  task automatic step();
    @(posedge clk_2); #1;
    drive();
    @(negedge clk_2);
    sample();
  endtask

  task automatic clr();
    n_start = 0; n_req = 0;
    bad_gnt = 0; bad_ack = 0;
    seen_q.delete(); gnt_log.delete(); ack_pos.delete();
  endtask

  task automatic set_smp(input int i, input int base);
    for (int k = 0; k < 16; k++) smp[i][k] = DW'(base + k);
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    int s;
    s = 0;
    for (int k = 0; k < FL; k++) s += int'(smp[i][k]);
    e.id = i; e.d = s / FL;
    exp_q.push_back(e);
  endtask

  task automatic run_empty(input int budget, output bit ok);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step(); c++;
    end
    ok = (exp_q.size() == 0);
    step(); step();
  endtask

  function automatic int log_code(input int q[$], input int off);
    int g;
    g = 0;
    foreach (q[k]) g = g * 10 + q[k] + off;
    return g;
  endfunction

  task automatic pulse_reset();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk_2);
    n_tot++;
    if ({bus.busy, bus.avg_start, bus.avg_req, bus.res_valid} !== 4'b0)
      $display("FAIL rst_ctrl: got %b, required 0000",
               {bus.busy, bus.avg_start, bus.avg_req, bus.res_valid});
    else n_pass++;
    n_tot++;
    if ({bus.src_gnt, bus.src_ack, bus.avg_data} !== '0)
      $display("FAIL rst_bus: got gnt=%b ack=%b data=%h, required 0",
               bus.src_gnt, bus.src_ack, bus.avg_data);
    else n_pass++;
    n_tot++;
    if ({bus.res_data, bus.res_id} !== '0)
      $display("FAIL rst_res: got data=%h id=%0d, required 0",
               bus.res_data, bus.res_id);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok, seq;
    clr();
    set_smp(1, 1);
    push_exp(1);
    frames_left[1] = 1;
    run_empty(40, ok);
    n_tot++;
    if (!ok) $display("FAIL single_done: got pending, required result");
    else n_pass++;
    n_tot++;
    if (n_start !== 1)
      $display("FAIL single_start: got %0d, required 1", n_start);
    else n_pass++;
    n_tot++;
    if (n_req !== FL)
      $display("FAIL single_req: got %0d, required %0d", n_req, FL);
    else n_pass++;
    seq = (seen_q.size() == FL);
    for (int k = 0; k < FL && seq; k++)
      if (seen_q[k] !== smp[1][k]) seq = 0;
    n_tot++;
    if (!seq) $display("FAIL single_data: got %0d samples, required 1,2,3,4",
                       seen_q.size());
    else n_pass++;
    // ptr should now be 2, so source 3 beats source 0
    clr();
    set_smp(3, 7); set_smp(0, 3);
    push_exp(3); push_exp(0);
    frames_left[3] = 1; frames_left[0] = 1;
    run_empty(80, ok);
    n_tot++;
    if (!ok || log_code(gnt_log, 1) !== 41)
      $display("FAIL single_ptr: got order %0d, required 41",
               log_code(gnt_log, 1));
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    pulse_reset();
    clr();
    set_smp(0, 2); set_smp(2, 9);
    frames_left[0] = 2; frames_left[2] = 2;
    push_exp(0); push_exp(2); push_exp(0); push_exp(2);
    run_empty(150, ok);
    n_tot++;
    if (!ok || log_code(gnt_log, 1) !== 1313)
      $display("FAIL rr_order: got %0d, required 1313",
               log_code(gnt_log, 1));
    else n_pass++;
    n_tot++;
    if (bad_gnt !== 0 || bad_ack !== 0)
      $display("FAIL rr_onehot: got gnt_err=%0d ack_err=%0d, required 0",
               bad_gnt, bad_ack);
    else n_pass++;
    n_tot++;
    if (n_start !== 4)
      $display("FAIL rr_start: got %0d, required 4", n_start);
    else n_pass++;
  endtask

  task automatic test_gaps();
    bit ok;
    clr();
    set_smp(3, 5);
    vpat[3] = 32'hFFFF_FFB3;
    push_exp(3);
    frames_left[3] = 1;
    run_empty(60, ok);
    n_tot++;
    if (!ok || log_code(ack_pos, 0) !== 1457)
      $display("FAIL gap_ack: got %0d, required 1457",
               log_code(ack_pos, 0));
    else n_pass++;
    n_tot++;
    if (n_req !== FL || bad_ack !== 0)
      $display("FAIL gap_req: got req=%0d ack_err=%0d, required 4 and 0",
               n_req, bad_ack);
    else n_pass++;
    vpat[3] = '1;
  endtask

  task automatic test_abort();
    bit ok;
    int c;
    pulse_reset();
    clr();
    set_smp(0, 4); set_smp(1, 11);
    frames_left[0] = 1; abort_after[0] = 2;
    frames_left[1] = 1;
    push_exp(1);
    c = 0;
    while (!(bus.src_gnt[0] && !bus.src_req[0]) && c < 30) begin
      step(); c++;
    end
    n_tot++;
    if (c >= 30) $display("FAIL abort_hit: got no drop, required drop");
    else n_pass++;
    step();
    n_tot++;
    if ({bus.busy, bus.res_valid, bus.src_gnt} !== '0)
      $display("FAIL abort_idle: got busy=%b res=%b gnt=%b, required 0",
               bus.busy, bus.res_valid, bus.src_gnt);
    else n_pass++;
    run_empty(60, ok);
    n_tot++;
    if (!ok || log_code(gnt_log, 1) !== 12)
      $display("FAIL abort_order: got %0d, required 12",
               log_code(gnt_log, 1));
    else n_pass++;
    n_tot++;
    if (n_start !== 2 || n_req !== 6)
      $display("FAIL abort_cnt: got start=%0d req=%0d, required 2 and 6",
               n_start, n_req);
    else n_pass++;
    abort_after[0] = -1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    clr();
    set_smp(2, 6);
    frames_left[2] = 1;
    c = 0;
    while (kcnt[2] != 3 && c < 30) begin
      step(); c++;
    end
    n_tot++;
    if (c >= 30) $display("FAIL rmid_hit: got %0d samples, required 3",
                          kcnt[2]);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_tot++;
    if ({bus.busy, bus.avg_start, bus.avg_req, bus.res_valid,
         bus.src_gnt, bus.src_ack, bus.avg_data,
         bus.res_data, bus.res_id} !== '0)
      $display("FAIL rmid_zero: got busy=%b gnt=%b req=%b rd=%h, required 0",
               bus.busy, bus.src_gnt, bus.avg_req, bus.res_data);
    else n_pass++;
    frames_left[2] = 0;
    step(); step();
    clr();
    set_smp(1, 2); set_smp(3, 8);
    frames_left[1] = 1; frames_left[3] = 1;
    push_exp(1); push_exp(3);
    rst = 1'b1;
    run_empty(100, ok);
    n_tot++;
    if (!ok || log_code(gnt_log, 1) !== 24)
      $display("FAIL rmid_order: got %0d, required 24",
               log_code(gnt_log, 1));
    else n_pass++;
    n_tot++;
    if (n_start !== 2 || n_req !== 8)
      $display("FAIL rmid_cnt: got start=%0d req=%0d, required 2 and 8",
               n_start, n_req);
    else n_pass++;
  endtask

`ifdef AVG_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c;
    clr();
    mute = 1'b1;
    n_to = 0; t_cyc = 0;
    set_smp(0, 1); set_smp(1, 3);
    frames_left[0] = 1; frames_left[1] = 1;
    push_exp(1);
    c = 0;
    while (n_to == 0 && c < 80) begin
      step(); c++;
    end
    n_tot++;
    if (n_to == 0 || t_cyc - c_req4 !== 16)
      $display("FAIL tmo_time: got %0d, required 16", t_cyc - c_req4);
    else n_pass++;
    mute = 1'b0;
    run_empty(60, ok);
    n_tot++;
    if (!ok || log_code(gnt_log, 1) !== 12 || n_to !== 1)
      $display("FAIL tmo_next: got order %0d errs %0d, required 12 and 1",
               log_code(gnt_log, 1), n_to);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.src_req    = '0;
    bus.src_valid  = '0;
    bus.src_data   = '0;
    bus.avg_done   = 1'b0;
    bus.avg_result = '0;
    dprev = '0; prev_gnt = '0;
    mute = 1'b0;
    cyc = 0; dly = 0; acc = 0; nacc = 0;
    c_req4 = 0; t_cyc = 0; n_to = 0;
    for (int i = 0; i < NS; i++) begin
      vpat[i] = '1;
      frames_left[i] = 0;
      abort_after[i] = -1;
      pos[i] = 0; kcnt[i] = 0;
      set_smp(i, 0);
    end
    clr();
    #3;
    test_reset();
    test_single();
    test_round_robin();
    test_gaps();
    test_abort();
    test_reset_mid();
`ifdef AVG_TIMEOUT_EN
    test_timeout();
`endif
    if (exp_q.size() != 0) begin
      n_tot++;
      $display("FAIL sb_left: got %0d pending, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
